// File: rtl/reg_writeback_arbiter.sv
// Write-port arbiter for the 32x32 register file: pipeline writeback has priority, MUL/DIV results queue in a small FIFO.
// Optional macro WB_FIFO_BYPASS_EN lets an MD result skip the empty FIFO when the port is idle.
module reg_writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PIPE_WRITE,
  input  logic [4:0]    PIPE_ADDR,
  input  logic [31:0]   PIPE_DATA,
  input  logic          MD_VALID,
  input  logic [4:0]    MD_ADDR,
  input  logic [31:0]   MD_DATA,
  output logic          MD_READY,
  input  logic [4:0]    RS1_ADDR,
  input  logic [4:0]    RS2_ADDR,
  output logic          PEND_HIT1,
  output logic          PEND_HIT2,
  output logic          STALL_REQ,
  output logic [AW:0]   COUNT,
  output logic          WB_WRITE,
  output logic [4:0]    WB_ADDR,
  output logic [31:0]   WB_DATA
);

  logic [4:0]            addr_mem [FIFO_DEPTH];
  logic [31:0]           data_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_reg, live_next;
  logic [FIFO_DEPTH-1:0] hit1_vec, hit2_vec;
  logic [AW-1:0]         rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]           count_reg, count_next;
  logic [SW-1:0]         starve_reg, starve_next;
  logic                  stall_reg, stall_next;
  logic                  wb_write_reg, wb_write_next;
  logic [4:0]            wb_addr_reg, wb_addr_next;
  logic [31:0]           wb_data_reg, wb_data_next;

  logic pipe_eff, empty, full, md_acc, head_live, pop, push, bypass;

  assign pipe_eff  = PIPE_WRITE && (PIPE_ADDR != 5'd0);
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign MD_READY  = !full && !RESET;
  assign md_acc    = MD_VALID && MD_READY;
  assign head_live = live_reg[rd_ptr_reg];
  assign pop       = !pipe_eff && !empty;

`ifdef WB_FIFO_BYPASS_EN
  assign bypass = md_acc && empty && !pipe_eff && (MD_ADDR != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // x0 results are accepted but never stored
  assign push = md_acc && (MD_ADDR != 5'd0) && !bypass;

  // Live bits: set on push (MD younger than a same-cycle pipe write), cleared on pop or WAW kill.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic kill;
      assign kill = pipe_eff && (addr_mem[gi] == PIPE_ADDR);
      assign live_next[gi] = (push && wr_ptr_reg == AW'(gi)) ? 1'b1 :
                             ((pop && rd_ptr_reg == AW'(gi)) || kill) ? 1'b0 : live_reg[gi];
      assign hit1_vec[gi] = live_reg[gi] && (addr_mem[gi] == RS1_ADDR);
      assign hit2_vec[gi] = live_reg[gi] && (addr_mem[gi] == RS2_ADDR);
    end
  endgenerate

  assign PEND_HIT1 = (|hit1_vec) && (RS1_ADDR != 5'd0);
  assign PEND_HIT2 = (|hit2_vec) && (RS2_ADDR != 5'd0);

  always_comb begin
    wb_write_next = 1'b0;
    wb_addr_next  = wb_addr_reg;
    wb_data_next  = wb_data_reg;
    if (pipe_eff) begin
      wb_write_next = 1'b1;
      wb_addr_next  = PIPE_ADDR;
      wb_data_next  = PIPE_DATA;
    end else if (!empty) begin
      wb_write_next = head_live;
      if (head_live) begin
        wb_addr_next = addr_mem[rd_ptr_reg];
        wb_data_next = data_mem[rd_ptr_reg];
      end
    end else if (bypass) begin
      wb_write_next = 1'b1;
      wb_addr_next  = MD_ADDR;
      wb_data_next  = MD_DATA;
    end
  end

  always_comb begin
    count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    stall_next = (starve_reg >= SW'(STARVE_LIMIT)) && !pop;
    starve_next = starve_reg;
    if (pop || empty)
      starve_next = '0;
    else if (pipe_eff && head_live && starve_reg != SW'(STARVE_LIMIT))
      starve_next = starve_reg + SW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= MD_ADDR;
      data_mem[wr_ptr_reg] <= MD_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      live_reg     <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      starve_reg   <= '0;
      stall_reg    <= 1'b0;
      wb_write_reg <= 1'b0;
      wb_addr_reg  <= 5'd0;
      wb_data_reg  <= 32'd0;
    end else begin
      live_reg     <= live_next;
      rd_ptr_reg   <= rd_ptr_reg + AW'(pop);
      wr_ptr_reg   <= wr_ptr_reg + AW'(push);
      count_reg    <= count_next;
      starve_reg   <= starve_next;
      stall_reg    <= stall_next;
      wb_write_reg <= wb_write_next;
      wb_addr_reg  <= wb_addr_next;
      wb_data_reg  <= wb_data_next;
    end
  end

  assign COUNT     = count_reg;
  assign STALL_REQ = stall_reg;
  assign WB_WRITE  = wb_write_reg;
  assign WB_ADDR   = wb_addr_reg;
  assign WB_DATA   = wb_data_reg;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed plus random bench for reg_writeback_arbiter against a queue-based reference model.
module tb_reg_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        PIPE_WRITE = 1'b0;
  logic [4:0]  PIPE_ADDR = '0;
  logic [31:0] PIPE_DATA = '0;
  logic        MD_VALID = 1'b0;
  logic [4:0]  MD_ADDR = '0;
  logic [31:0] MD_DATA = '0;
  logic        MD_READY;
  logic [4:0]  RS1_ADDR = '0;
  logic [4:0]  RS2_ADDR = '0;
  logic        PEND_HIT1, PEND_HIT2, STALL_REQ;
  logic [2:0]  COUNT;
  logic        WB_WRITE;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;

  reg_writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .PIPE_WRITE(PIPE_WRITE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
    .MD_VALID(MD_VALID), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
    .PEND_HIT1(PEND_HIT1), .PEND_HIT2(PEND_HIT2), .STALL_REQ(STALL_REQ), .COUNT(COUNT),
    .WB_WRITE(WB_WRITE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          starve_m = 0;
  bit          stall_m = 0;
  bit          wbw_m = 0;
  logic [4:0]  wba_m = '0;
  logic [31:0] wbd_m = '0;
  bit          have_exp = 0;
  bit          just_reset = 0;
  int          total = 0;
  int          bad = 0;
  int          nstep = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].a == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input bit rst, input bit pw, input logic [4:0] pa, input logic [31:0] pd,
                      input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [4:0] r1, input logic [4:0] r2);
    int   sz;
    bit   ready, pe, acc, hl, byp, popped;
    ent_t e;
    @(negedge CLK);
    RESET = rst; PIPE_WRITE = pw; PIPE_ADDR = pa; PIPE_DATA = pd;
    MD_VALID = mv; MD_ADDR = ma; MD_DATA = md; RS1_ADDR = r1; RS2_ADDR = r2;
    #1;
    sz    = q.size();
    ready = (sz != DEPTH) && !rst;
    chk("md_ready", {31'd0, MD_READY}, {31'd0, ready});
    if (have_exp) begin
      chk("wb_write", {31'd0, WB_WRITE}, {31'd0, wbw_m});
      if (wbw_m || just_reset) begin
        chk("wb_addr", {27'd0, WB_ADDR}, {27'd0, wba_m});
        chk("wb_data", WB_DATA, wbd_m);
      end
      chk("stall_req", {31'd0, STALL_REQ}, {31'd0, stall_m});
      chk("count", {29'd0, COUNT}, sz);
      chk("pend_hit1", {31'd0, PEND_HIT1}, {31'd0, pend(r1)});
      chk("pend_hit2", {31'd0, PEND_HIT2}, {31'd0, pend(r2)});
    end
    $display("step %0d rst=%0b pipe=%0b x%0d md=%0b x%0d rdy=%0b wb=%0b x%0d %h cnt=%0d stall=%0b",
             nstep, rst, pw, pa, mv, ma, MD_READY, WB_WRITE, WB_ADDR, WB_DATA, COUNT, STALL_REQ);
    nstep++;
    just_reset = 0;
    if (rst) begin
      q.delete();
      starve_m = 0; stall_m = 0; wbw_m = 0; wba_m = '0; wbd_m = '0;
      have_exp = 1; just_reset = 1;
    end else begin
      pe     = pw && (pa != 5'd0);
      acc    = mv && ready;
      hl     = (sz > 0) && q[0].live;
      byp    = 1'b0;
`ifdef WB_FIFO_BYPASS_EN
      byp    = acc && (sz == 0) && !pe && (ma != 5'd0);
`endif
      popped = !pe && (sz > 0);
      stall_m = (starve_m >= LIMIT) && !popped;
      if (popped || sz == 0) starve_m = 0;
      else if (pe && hl) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
      if (pe) begin
        wbw_m = 1; wba_m = pa; wbd_m = pd;
        foreach (q[i]) if (q[i].a == pa) q[i].live = 1'b0;
      end else if (popped) begin
        e = q.pop_front();
        wbw_m = e.live;
        if (e.live) begin wba_m = e.a; wbd_m = e.d; end
      end else if (byp) begin
        wbw_m = 1; wba_m = ma; wbd_m = md;
      end else begin
        wbw_m = 0;
      end
      if (acc && ma != 5'd0 && !byp) q.push_back(ent_t'{ma, md, 1'b1});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd9);
  endtask

  initial begin
    // reset with MD_VALID high: MD_READY must be low
    step(1, 0, 5'd0, 32'd0, 1, 5'd7, 32'h99, 5'd0, 5'd0);
    idle(1);
    // pipe-only writes, x0 dropped
    step(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    step(0, 1, 5'd0, 32'h5555, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(1);
    // contention: x7 starved under continuous pipe writes, then a bubble
    step(0, 1, 5'd1, 32'hA0, 1, 5'd7, 32'hAA, 5'd7, 5'd0);
    for (int i = 0; i < 11; i++)
      step(0, 1, 5'((i % 6) + 1), 32'hB0 + i, 0, 5'd0, 32'd0, 5'd7, 5'd0);
    step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(2);
    // fill FIFO under pipe writes, then drain in order
    for (int i = 0; i < 6; i++)
      step(0, 1, 5'd1, 32'(i), 1, 5'(10 + i), 32'hC0 + i, 5'd10, 5'd13);
    idle(6);
    // WAW kill of a queued entry
    step(0, 1, 5'd1, 32'd0, 1, 5'd9, 32'h11, 5'd9, 5'd0);
    step(0, 1, 5'd9, 32'h22, 0, 5'd0, 32'd0, 5'd9, 5'd0);
    idle(3);
    // idle port, single MD result
    idle(1);
    step(0, 0, 5'd0, 32'd0, 1, 5'd3, 32'h5, 5'd3, 5'd0);
    idle(3);
    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(199) == 0,
           $urandom_range(99) < 60, 5'($urandom_range(7)), $urandom,
           $urandom_range(1), 5'($urandom_range(7)), $urandom,
           5'($urandom_range(7)), 5'($urandom_range(7)));
    end
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
